// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - eight-way round-robin arbiter with one-hot grant and hold-time limit
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           st;
  logic [2:0]       ptr;
  logic [2:0]       winner;
  logic [CNT_W-1:0] cnt;
  logic             owner_req;
  logic             at_limit;
  logic             grant_end;

  // Scan from the farthest offset down so the one closest to ptr wins last.
  always_comb begin
    winner = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr + 3'(i)]) winner = ptr + 3'(i);
    end
  end

  assign owner_req = req[gnt_idx];
  assign at_limit  = (cnt == CNT_W'(HOLD_MAX - 1));
  assign grant_end = done | ~owner_req | at_limit;

  assign busy = (st == GRANT);
  assign gnt  = busy ? (8'h01 << gnt_idx) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      ptr     <= 3'd0;
      gnt_idx <= 3'd0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          timeout <= 1'b0;
          if (|req) begin
            gnt_idx <= winner;
            cnt     <= '0;
            st      <= GRANT;
          end
        end
        GRANT: begin
          if (grant_end) begin
            st      <= IDLE;
            ptr     <= gnt_idx + 3'd1;
            // Only a pure limit expiry counts as a timeout.
            timeout <= at_limit & ~done & owner_req;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            timeout <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_8 #(.HOLD_MAX(15), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 8'h00 || busy !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: gnt=%h busy=%b idx=%0d to=%b, want 00 0 0 0",
                 i, gnt, busy, gnt_idx, timeout);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h20;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 8'h20 || gnt_idx !== 3'd5 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_grant cyc%0d: gnt=%h idx=%0d busy=%b, want 20 5 1",
                 k, gnt, gnt_idx, busy);
      end
      if (k == 3) done = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0 || gnt_idx !== 3'd5) begin
      errors++;
      $display("FAIL single_end: gnt=%h to=%b idx=%0d, want 00 0 5", gnt, timeout, gnt_idx);
    end
    done = 1'b0;
    req  = 8'h41;
    @(negedge clk);
    checks++;
    if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin
      errors++;
      $display("FAIL single_ptr6: gnt=%h idx=%0d, want 40 6", gnt, gnt_idx);
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h01;
    exp_seq[1] = 8'h80;
    exp_seq[2] = 8'h01;
    exp_seq[3] = 8'h80;
    do_reset();
    req = 8'h81;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      checks++;
      if (gnt !== exp_seq[g] || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%h busy=%b, want %h 1", g, gnt, busy, exp_seq[g]);
      end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      checks++;
      if (gnt !== 8'h00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_dead%0d: gnt=%h busy=%b, want 00 0", g, gnt, busy);
      end
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h04;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 8'h04 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold cyc%0d: gnt=%h to=%b, want 04 0", k, gnt, timeout);
      end
    end
    @(negedge clk);
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_pulse: gnt=%h to=%b, want 00 1", gnt, timeout);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 8'h04 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_regrant: gnt=%h to=%b, want 04 0", gnt, timeout);
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_done_at_limit();
    do_reset();
    req = 8'h04;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 8'h04) begin
        errors++;
        $display("FAIL lim_hold cyc%0d: gnt=%h, want 04", k, gnt);
      end
      if (k == 15) done = 1'b1;
    end
    @(negedge clk);
    done = 1'b0;
    req  = 8'h00;
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL lim_done: gnt=%h to=%b, want 00 0", gnt, timeout);
    end
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 8'h08;
    @(negedge clk);
    checks++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL drop_grant: gnt=%h idx=%0d, want 08 3", gnt, gnt_idx);
    end
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    checks++;
    if (gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 3'd3) begin
      errors++;
      $display("FAIL drop_end: gnt=%h busy=%b to=%b idx=%0d, want 00 0 0 3",
               gnt, busy, timeout, gnt_idx);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h10;
    @(negedge clk);
    checks++;
    if (gnt !== 8'h10) begin
      errors++;
      $display("FAIL ar_grant: gnt=%h, want 10", gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || busy !== 1'b0 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL ar_drop: gnt=%h busy=%b idx=%0d, want 00 0 0", gnt, busy, gnt_idx);
    end
    req = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL ar_first: gnt=%h idx=%0d, want 01 0", gnt, gnt_idx);
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_req_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that shares one resource among eight requesters. It picks a winner as a 3-bit index and drives the index through a 3-to-8 one-hot decode to form the grant vector. It holds the grant until the winner signals completion, drops its request, or hits a hold-time limit. It sits between requester blocks and any shared datapath (bus, display digit, memory port) that is steered by a one-hot select.

## Interface
- HOLD_MAX, 15: maximum number of cycles a single grant may last; legal range 1..(2^CNT_W).
- CNT_W, 4: width of the hold counter; must hold HOLD_MAX-1.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low; clears all state immediately.
- req  input  8  request vector; bit i high means requester i wants the resource.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- gnt  output  8  one-hot grant: decoded gnt_idx when busy=1, else 8'h00.
- gnt_idx  output  3  index of the current or most recent owner.
- busy  output  1  high while a grant is active (state GRANT).
- timeout  output  1  one-cycle pulse when a grant was ended by the hold limit.

## Operation
- State: st (IDLE/GRANT), ptr[2:0] (highest-priority index for the next arbitration), gnt_idx[2:0], cnt[CNT_W-1:0], timeout register.
- Reset values: st=IDLE, ptr=0, gnt_idx=0, cnt=0, busy=0, gnt=8'h00, timeout=0.
- IDLE, req==0: remain in IDLE. All outputs hold, except timeout, which is forced to 0 after its pulse cycle.
- IDLE, req!=0: the winner is the first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8, wrapping 7->0).
  - Next edge: gnt_idx<=winner, cnt<=0, st<=GRANT.
- GRANT: cnt increments each cycle. The grant ends at an edge when any of these is true:
  - (a) done==1;
  - (b) req[gnt_idx]==0;
  - (c) cnt==HOLD_MAX-1.
- On end:
  - st<=IDLE, ptr<=gnt_idx+1 (3-bit wrap, so 7->0).
  - timeout<=1 only if (c) is true and neither (a) nor (b) is true; otherwise timeout<=0.
  - gnt_idx keeps its value.
- Requests from non-owners are ignored during GRANT. Those requesters must keep req high to be considered at the next arbitration.
- gnt is combinational from the registered busy/gnt_idx: gnt[i] = busy & (gnt_idx==i). It is never multi-hot.
- Starvation bound: a requester that holds req continuously is granted within 7 grants, each of at most HOLD_MAX cycles plus one IDLE cycle.

## Timing
- Grant latency: if req is sampled nonzero at edge N in IDLE, busy and gnt are high from edge N to the ending edge. There is one cycle of arbitration latency from request to grant.
- Grant length: if done is sampled high at the k-th edge after the grant starts, the grant lasts k cycles. Maximum length is HOLD_MAX cycles.
- Every grant is followed by at least one IDLE cycle with gnt=8'h00. Back-to-back grants to different requesters are therefore separated by exactly one dead cycle.
- timeout is high for exactly the one IDLE cycle after a limit-ended grant.
- done is ignored in IDLE.
- rst_n low mid-grant: gnt drops to 8'h00 asynchronously and all state returns to reset values. After release, arbitration starts from ptr=0.
- HOLD_MAX=1: every grant lasts exactly one cycle. timeout pulses only if done=0 and the owner's req is still high at that edge.

## Test plan
- Reset/idle: hold rst_n=0, then release with req=8'h00 for 5 cycles. Required: gnt=8'h00, busy=0, gnt_idx=0, timeout=0 throughout.
- Single requester: req=8'h20, then done=1 at the 3rd edge of the grant. Required: gnt=8'h20 and gnt_idx=5 for 3 cycles, then gnt=8'h00; ptr becomes 6; no timeout.
- Round robin with wrap: req=8'h81 held, done pulsed at the end of each grant. Required: grant sequence 8'h01, 8'h80, 8'h01, 8'h80, with exactly one idle cycle between grants.
- Timeout: HOLD_MAX=15, req=8'h04 held, done=0. Required: gnt=8'h04 for exactly 15 cycles, then timeout=1 for 1 cycle with gnt=8'h00, then gnt=8'h04 again on the next cycle.
- Done coincident with the limit, and request drop: done=1 at the 15th edge gives timeout=0. A separate grant where req[owner] falls mid-grant ends at that edge with timeout=0.
- Async reset mid-grant: assert rst_n=0 between clock edges during gnt=8'h10. Required: gnt=8'h00 immediately, without waiting for an edge. After release with req=8'hFF, the first grant is 8'h01.
